// File: rtl/vec_iq_pkg.sv
// Shared types and opcode constants for the vector instruction queue.
package vec_iq_pkg;

    localparam int IQ_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } iq_state_e;

    localparam logic [6:0] OPC_OPV    = 7'b1010111;
    localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
    localparam logic [6:0] OPC_VSTORE = 7'b0100111;

    typedef struct packed {
        logic [IQ_XLEN-1:0] inst;
        logic [IQ_XLEN-1:0] rs1;
        logic [IQ_XLEN-1:0] rs2;
    } iq_entry_t;

    function automatic logic opc_is_vec(input logic [6:0] opc);
        return (opc == OPC_OPV) || (opc == OPC_VLOAD) || (opc == OPC_VSTORE);
    endfunction

endpackage

// File: rtl/vec_iq_fifo.sv
// Synchronous FIFO of queue entries; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module vec_iq_fifo
    import vec_iq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = iq_entry_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     wdata,
    output entry_t                     rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (reset && !clear && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vec_inst_queue.sv
// Buffered vector instruction front-end: opcode filter, issue FSM, optional
// WAIT_ACK watchdog enabled by defining VEC_IQ_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | nothing in flight, pop head when FIFO not empty
//   ISSUE    | issue_valid pulse, instruction handed to vector core
//   WAIT_ACK | waiting for vec_pro_ack (or watchdog expiry)
module vec_inst_queue
    import vec_iq_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inst_valid,
    input  logic [XLEN-1:0]        instruction,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    output logic                   inst_ready,
    output logic                   is_vec,
    output logic                   illegal_inst,
    input  logic                   flush,
    output logic                   issue_valid,
    output logic [XLEN-1:0]        issue_inst,
    output logic [XLEN-1:0]        issue_rs1,
    output logic [XLEN-1:0]        issue_rs2,
    input  logic                   vec_pro_ack,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   timeout_err
);

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } entry_t;

    iq_state_e state;
    entry_t    wr_entry;
    entry_t    head;
    logic      fifo_full;
    logic      fifo_empty;
    logic      accept;
    logic      push;
    logic      pop;
    logic      wd_expire;
    logic      ack_like;

    assign is_vec     = opc_is_vec(instruction[6:0]);
    assign inst_ready = !fifo_full && !flush;
    assign accept     = inst_valid && inst_ready;
    assign push       = accept && is_vec;
    assign wr_entry   = '{inst: instruction, rs1: rs1_data, rs2: rs2_data};
    assign ack_like   = vec_pro_ack || wd_expire;

    // Pop either from IDLE or straight out of WAIT_ACK for back-to-back issue.
    always_comb begin
        pop = 1'b0;
        if (!flush && !fifo_empty) begin
            pop = (state == IDLE) || ((state == WAIT_ACK) && ack_like);
        end
    end

    vec_iq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

`ifdef VEC_IQ_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WDW-1:0] wd_cnt;

    // Held at zero outside WAIT_ACK, so it starts from zero on every entry.
    always_ff @(posedge clk) begin
        if (!reset || (state != WAIT_ACK)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end

    assign wd_expire   = (state == WAIT_ACK) && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1))
                         && !vec_pro_ack && !flush;
    assign timeout_err = wd_expire;
`else
    assign wd_expire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            issue_valid  <= 1'b0;
            busy         <= 1'b0;
            illegal_inst <= 1'b0;
            issue_inst   <= '0;
            issue_rs1    <= '0;
            issue_rs2    <= '0;
        end else begin
            illegal_inst <= accept && !is_vec;
            issue_valid  <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (pop) begin
                issue_inst  <= head.inst;
                issue_rs1   <= head.rs1;
                issue_rs2   <= head.rs2;
                issue_valid <= 1'b1;
                busy        <= 1'b1;
                state       <= ISSUE;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    ISSUE: begin
                        if (vec_pro_ack) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_ACK;
                        end
                    end
                    WAIT_ACK: begin
                        if (ack_like) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
